// File: rtl/pio_mem_mux.sv
// pio_mem_mux
//   Fans one PIO register-bus access out to one of NUM_TGT memory/register
//   targets. The target is chosen by a select field in reg_addr. The block
//   returns a single acknowledge and a registered read response. A per-access
//   timeout guarantees that an access always completes, and sticky status
//   bits record timed-out and unmapped accesses.
//
// Ports
//   clk, rst          core clock, asynchronous active-high reset
//   clk_div           one-clk strobe marking the PIO bus sampling edge
//   reg_bs            block select
//   reg_wr, reg_rd    write / read request pulses
//   reg_addr          access address; the select field is at SEL_LSB
//   tgt_ack           per-target acknowledge
//   tgt_rdata         per-target read data, target i at [i*PIO_NBITS +: PIO_NBITS]
//   reg_ms            one-hot target select, high while an access waits on a target
//   pio_ack           access complete, one clk wide, on a clk_div cycle
//   pio_rvalid        pio_ack qualified by "access was a read"
//   pio_rdata         registered read data; it holds its value across writes
//   err_clr           clears the error status (a coincident new error wins)
//   err_timeout       sticky: a target did not ack within TIMEOUT ticks
//   err_unmapped      sticky: an access selected an index >= NUM_TGT
//   err_cnt           saturating count of errored accesses
//   dbg_state         current FSM state (0 idle, 1 wait, 2 resp)
//
// Handshake: a request is (reg_rd | reg_wr) & reg_bs, sampled in IDLE only.
// Requests seen outside IDLE are dropped, because the bus keeps at most one
// access outstanding. Targets answer by raising tgt_ack on a clk_div cycle.
// The mux answers with pio_ack (and pio_rvalid for reads) on a later clk_div
// cycle. A new request may be presented in the cycle after pio_ack.

module pio_mem_mux #(
    parameter int                   NUM_TGT   = 4,
    parameter int                   PIO_NBITS = 32,
    parameter int                   SEL_LSB   = 12,
    parameter int                   SEL_NBITS = 4,
    parameter int                   TIMEOUT   = 64,
    parameter logic [PIO_NBITS-1:0] ERR_DATA  = 32'hDEAD_0BAD
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           clk_div,
    input  logic                           reg_bs,
    input  logic                           reg_wr,
    input  logic                           reg_rd,
    input  logic [PIO_NBITS-1:0]           reg_addr,
    input  logic [NUM_TGT-1:0]             tgt_ack,
    input  logic [NUM_TGT*PIO_NBITS-1:0]   tgt_rdata,
    output logic [NUM_TGT-1:0]             reg_ms,
    output logic                           pio_ack,
    output logic                           pio_rvalid,
    output logic [PIO_NBITS-1:0]           pio_rdata,
    input  logic                           err_clr,
    output logic                           err_timeout,
    output logic                           err_unmapped,
    output logic [7:0]                     err_cnt,
    output logic [1:0]                     dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [SEL_NBITS:0] NUM_TGT_W = (SEL_NBITS+1)'(NUM_TGT);
    localparam logic [7:0]         TO_LAST   = 8'(TIMEOUT - 1);

    state_t                 state;
    state_t                 state_nxt;
    logic [SEL_NBITS-1:0]   sel_q;
    logic                   is_rd_q;
    logic                   err_flag_q;   // current access ends in an error
    logic                   err_unm_q;    // ...and that error is "unmapped"
    logic [7:0]             to_cnt;

    logic                   req;
    logic [SEL_NBITS-1:0]   addr_sel;
    logic                   addr_mapped;
    logic                   sel_ack;
    logic [PIO_NBITS-1:0]   sel_rdata;
    logic                   timeout_hit;
    logic                   resp_tick;
    logic                   err_evt;
    logic                   unused_addr_bits;

    assign req         = (reg_rd | reg_wr) & reg_bs;
    assign addr_sel    = reg_addr[SEL_LSB +: SEL_NBITS];
    assign addr_mapped = ({1'b0, addr_sel} < NUM_TGT_W);
    assign timeout_hit = (to_cnt == TO_LAST);
    assign resp_tick   = (state == S_RESP) && clk_div;
    assign err_evt     = resp_tick && err_flag_q;
    assign dbg_state   = state;

    // Only the select field of the address matters to this block.
    assign unused_addr_bits = ^reg_addr;

    // Pick the selected target's ack/data. Acks from other targets are never
    // looked at.
    always_comb begin
        sel_ack   = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < NUM_TGT; i++) begin
            if (sel_q == SEL_NBITS'(i)) begin
                sel_ack   = tgt_ack[i];
                sel_rdata = tgt_rdata[i*PIO_NBITS +: PIO_NBITS];
            end
        end
    end

    always_comb begin
        reg_ms = '0;
        for (int i = 0; i < NUM_TGT; i++) begin
            reg_ms[i] = (state == S_WAIT) && (sel_q == SEL_NBITS'(i));
        end
    end

    // pio_ack is decoded from the state register and the bus strobe. This
    // makes the pulse land exactly on the RESP clk_div cycle, and IDLE
    // resumes on the next clk.
    assign pio_ack    = resp_tick;
    assign pio_rvalid = resp_tick && is_rd_q;

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (req) begin
                    state_nxt = addr_mapped ? S_WAIT : S_RESP;
                end
            end
            S_WAIT: begin
                if (clk_div && (sel_ack || timeout_hit)) begin
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (clk_div) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Access context, timeout counter and read data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q      <= '0;
            is_rd_q    <= 1'b0;
            err_flag_q <= 1'b0;
            err_unm_q  <= 1'b0;
            to_cnt     <= '0;
            pio_rdata  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req) begin
                        sel_q   <= addr_sel;
                        is_rd_q <= reg_rd;
                        to_cnt  <= '0;
                        if (addr_mapped) begin
                            err_flag_q <= 1'b0;
                            err_unm_q  <= 1'b0;
                        end else begin
                            err_flag_q <= 1'b1;
                            err_unm_q  <= 1'b1;
                            // Writes never disturb the read-data register.
                            if (reg_rd) begin
                                pio_rdata <= ERR_DATA;
                            end
                        end
                    end
                end
                S_WAIT: begin
                    if (clk_div) begin
                        if (sel_ack) begin
                            if (is_rd_q) begin
                                pio_rdata <= sel_rdata;
                            end
                        end else if (timeout_hit) begin
                            // to_cnt counts the ack-less ticks already seen.
                            // This tick is number TIMEOUT.
                            err_flag_q <= 1'b1;
                            err_unm_q  <= 1'b0;
                            if (is_rd_q) begin
                                pio_rdata <= ERR_DATA;
                            end
                        end else begin
                            to_cnt <= to_cnt + 8'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Sticky error status. A new error on the same cycle as err_clr wins, so
    // the count restarts at one instead of zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_timeout  <= 1'b0;
            err_unmapped <= 1'b0;
            err_cnt      <= '0;
        end else if (err_clr) begin
            err_timeout  <= err_evt && !err_unm_q;
            err_unmapped <= err_evt && err_unm_q;
            err_cnt      <= err_evt ? 8'd1 : 8'd0;
        end else if (err_evt) begin
            if (err_unm_q) begin
                err_unmapped <= 1'b1;
            end else begin
                err_timeout <= 1'b1;
            end
            if (err_cnt != 8'hFF) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_pio_mem_mux.sv
// tb_pio_mem_mux
//   Directed testbench for pio_mem_mux with NUM_TGT=4 and TIMEOUT=8. clk_div
//   strobes every fourth clk. Expected responses ({rvalid, rdata}) are pushed
//   when a request is issued. A monitor pops one entry on every pio_ack and
//   compares it. The directed flow also checks target select, latency in
//   clk_div ticks and the error status.

module tb_pio_mem_mux;

    localparam int          W        = 32;
    localparam int          NT       = 4;
    localparam logic [31:0] ERR_DATA = 32'hDEAD_0BAD;
    localparam logic [1:0]  ST_IDLE  = 2'd0;
    localparam logic [1:0]  ST_WAIT  = 2'd1;
    localparam logic [1:0]  ST_RESP  = 2'd2;

    logic               clk = 1'b0;
    logic               rst;
    logic               clk_div = 1'b0;
    logic               reg_bs;
    logic               reg_wr;
    logic               reg_rd;
    logic [W-1:0]       reg_addr;
    logic [NT-1:0]      tgt_ack;
    logic [NT*W-1:0]    tgt_rdata;
    logic [NT-1:0]      reg_ms;
    logic               pio_ack;
    logic               pio_rvalid;
    logic [W-1:0]       pio_rdata;
    logic               err_clr;
    logic               err_timeout;
    logic               err_unmapped;
    logic [7:0]         err_cnt;
    logic [1:0]         dbg_state;

    logic [W:0]         exp_q[$];
    int                 n_cmp = 0;
    int                 n_err = 0;
    int                 div_cnt = 0;

    pio_mem_mux #(
        .NUM_TGT   (NT),
        .PIO_NBITS (W),
        .SEL_LSB   (12),
        .SEL_NBITS (4),
        .TIMEOUT   (8),
        .ERR_DATA  (ERR_DATA)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .clk_div      (clk_div),
        .reg_bs       (reg_bs),
        .reg_wr       (reg_wr),
        .reg_rd       (reg_rd),
        .reg_addr     (reg_addr),
        .tgt_ack      (tgt_ack),
        .tgt_rdata    (tgt_rdata),
        .reg_ms       (reg_ms),
        .pio_ack      (pio_ack),
        .pio_rvalid   (pio_rvalid),
        .pio_rdata    (pio_rdata),
        .err_clr      (err_clr),
        .err_timeout  (err_timeout),
        .err_unmapped (err_unmapped),
        .err_cnt      (err_cnt),
        .dbg_state    (dbg_state)
    );

    // ---------------- clock / reset block ----------------
    always #5 clk = ~clk;

    // clk_div: one clk high every four clks, updated just after the edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            clk_div = (div_cnt == 3);
            div_cnt = (div_cnt + 1) % 4;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic check_err(input logic to, input logic unm, input logic [7:0] cnt);
        check("err_timeout", 64'(err_timeout), 64'(to));
        check("err_unmapped", 64'(err_unmapped), 64'(unm));
        check("err_cnt", 64'(err_cnt), 64'(cnt));
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (!rst && pio_ack) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL resp: got unexpected pio_ack rdata=%0h required no ack", pio_rdata);
            end else begin
                logic [W:0] e;
                e = exp_q.pop_front();
                check("resp {rvalid,rdata}", 64'({pio_rvalid, pio_rdata}), 64'(e));
            end
            check("reg_ms in resp", 64'(reg_ms), 64'(0));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_tgt(input int i, input logic [W-1:0] d);
        tgt_rdata[i*W +: W] = d;
    endtask

    // Request accepted at the first edge after the task drives it. Returns
    // shortly after that edge.
    task automatic issue(input logic rd, input logic [W-1:0] addr);
        @(posedge clk);
        #2;
        reg_bs   = 1'b1;
        reg_rd   = rd;
        reg_wr   = ~rd;
        reg_addr = addr;
        @(posedge clk);
        #2;
        reg_bs   = 1'b0;
        reg_rd   = 1'b0;
        reg_wr   = 1'b0;
    endtask

    // Raise tgt_ack[sel] during the n-th clk_div tick, counting the current
    // cycle as the first candidate.
    task automatic ack_on_tick(input int sel, input int n);
        int k;
        k = 0;
        for (int c = 0; c < 400; c++) begin
            if (clk_div) begin
                k++;
                if (k == n) begin
                    tgt_ack[sel] = 1'b1;
                    @(posedge clk);
                    #2;
                    tgt_ack[sel] = 1'b0;
                    return;
                end
            end
            @(posedge clk);
            #2;
        end
        $display("FAIL ack_on_tick: got no tick %0d required tick seen", n);
        n_cmp++;
        n_err++;
    endtask

    // Waits for pio_ack. Counts clk_div ticks, including the ack tick, from
    // the current cycle onward.
    task automatic wait_ack(output int ticks);
        bit seen;
        seen  = 1'b0;
        ticks = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (clk_div) ticks++;
            if (pio_ack) begin
                seen = 1'b1;
                break;
            end
        end
        check("ack seen within budget", 64'(seen), 64'(1));
    endtask

    // ---------------- directed flow ----------------
    initial begin
        int ticks;
        bit hit;
        rst       = 1'b1;
        reg_bs    = 1'b0;
        reg_wr    = 1'b0;
        reg_rd    = 1'b0;
        reg_addr  = '0;
        tgt_ack   = '0;
        tgt_rdata = '0;
        err_clr   = 1'b0;
        set_tgt(0, 32'h0000_AAAA);
        set_tgt(1, 32'hA5A5_0001);
        set_tgt(2, 32'h1234_5678);
        set_tgt(3, 32'h3333_3333);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset state", 64'(dbg_state), 64'(ST_IDLE));
        check("reset reg_ms", 64'(reg_ms), 64'(0));
        check("reset pio_ack", 64'({pio_ack, pio_rvalid}), 64'(0));
        check("reset pio_rdata", 64'(pio_rdata), 64'(0));
        check_err(1'b0, 1'b0, 8'd0);
        #2 rst = 1'b0;

        // 1: read sel=2, ack on the 3rd tick -> pio_ack on the 4th tick
        exp_q.push_back({1'b1, 32'h1234_5678});
        issue(1'b1, 32'h0000_2000);
        fork
            ack_on_tick(2, 3);
            wait_ack(ticks);
            begin
                @(negedge clk);
                check("read reg_ms", 64'(reg_ms), 64'(4'b0100));
                check("read state wait", 64'(dbg_state), 64'(ST_WAIT));
            end
        join
        check("read latency ticks", 64'(ticks), 64'(4));
        @(negedge clk);
        check("ack single cycle", 64'(pio_ack), 64'(0));
        check("rdata held", 64'(pio_rdata), 64'(32'h1234_5678));
        check_err(1'b0, 1'b0, 8'd0);

        // 2: write sel=0, ack on the 1st tick, rdata unchanged
        exp_q.push_back({1'b0, 32'h1234_5678});
        issue(1'b0, 32'h0000_0000);
        fork
            ack_on_tick(0, 1);
            wait_ack(ticks);
        join
        check("write latency ticks", 64'(ticks), 64'(2));

        // 3: read sel=1, no ack -> timeout after 8 ticks
        exp_q.push_back({1'b1, ERR_DATA});
        issue(1'b1, 32'h0000_1000);
        wait_ack(ticks);
        check("timeout latency ticks", 64'(ticks), 64'(9));
        @(negedge clk);
        check_err(1'b1, 1'b0, 8'd1);

        // 4: unmapped sel=9, then 299 more to saturate err_cnt
        exp_q.push_back({1'b1, ERR_DATA});
        issue(1'b1, 32'h0000_9000);
        fork
            wait_ack(ticks);
            begin
                @(negedge clk);
                check("unmapped reg_ms", 64'(reg_ms), 64'(0));
                check("unmapped state resp", 64'(dbg_state), 64'(ST_RESP));
            end
        join
        check("unmapped latency ticks", 64'(ticks), 64'(1));
        @(negedge clk);
        check_err(1'b1, 1'b1, 8'd2);
        for (int i = 0; i < 299; i++) begin
            exp_q.push_back({1'b1, ERR_DATA});
            issue(1'b1, 32'h0000_9000);
            wait_ack(ticks);
        end
        @(negedge clk);
        check_err(1'b1, 1'b1, 8'd255);
        @(posedge clk);
        #2 err_clr = 1'b1;
        @(posedge clk);
        #2 err_clr = 1'b0;
        @(negedge clk);
        check_err(1'b0, 1'b0, 8'd0);

        // 5: foreign ack and a second request during WAIT are ignored
        exp_q.push_back({1'b1, 32'hA5A5_0001});
        issue(1'b1, 32'h0000_1000);
        tgt_ack[3] = 1'b1;
        issue(1'b1, 32'h0000_2000);
        @(negedge clk);
        check("ignored req state", 64'(dbg_state), 64'(ST_WAIT));
        check("ignored req reg_ms", 64'(reg_ms), 64'(4'b0010));
        fork
            ack_on_tick(1, 3);
            wait_ack(ticks);
        join
        tgt_ack[3] = 1'b0;
        repeat (16) @(negedge clk);
        check("one ack only", 64'(exp_q.size()), 64'(0));
        check("state idle after", 64'(dbg_state), 64'(ST_IDLE));

        // 6: reset during WAIT aborts with no ack
        issue(1'b1, 32'h0000_0000);
        @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        check("rst reg_ms", 64'(reg_ms), 64'(0));
        check("rst state", 64'(dbg_state), 64'(ST_IDLE));
        check("rst pio_rdata", 64'(pio_rdata), 64'(0));
        @(posedge clk);
        #2 rst = 1'b0;
        repeat (16) @(negedge clk);
        check("rst no ack", 64'({pio_ack, dbg_state}), 64'(0));

        // 7: err_clr together with a timeout response -> error wins
        exp_q.push_back({1'b1, ERR_DATA});
        issue(1'b1, 32'h0000_F000);
        wait_ack(ticks);
        @(negedge clk);
        check_err(1'b0, 1'b1, 8'd1);
        exp_q.push_back({1'b1, ERR_DATA});
        issue(1'b1, 32'h0000_3000);
        hit = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk);
            #2;
            if (clk_div && dbg_state == ST_RESP) begin
                err_clr = 1'b1;
                @(posedge clk);
                #2 err_clr = 1'b0;
                hit = 1'b1;
                break;
            end
        end
        check("clr/timeout resp reached", 64'(hit), 64'(1));
        @(negedge clk);
        check_err(1'b1, 1'b0, 8'd1);

        repeat (8) @(negedge clk);
        check("scoreboard drained", 64'(exp_q.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
